icg_enable_ctrl: RTL and testbench
==================================

ICG_ENABLE_CTRL -- requirements
Module: icg_enable_ctrl

Interface
REQ-001 Parameter WAKE_CYCLES, default 2: cycles E is held high before ACK asserts; legal range 1..15.
REQ-002 Parameter IDLE_W, default 8: width of the IDLE_LIMIT input and of the idle counter.
REQ-003 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset; asynchronous, active-high.
REQ-005 REQ  input  1  requester needs the gated clock; level-sensitive.
REQ-006 BUSY  input  1  gated domain still active; blocks gating.
REQ-007 SCAN_EN  input  1  test mode; forces the gate transparent.
REQ-008 IDLE_LIMIT  input  IDLE_W  idle cycles tolerated before gating; 0 disables auto-gating.
REQ-009 E  output  1  functional enable to the integrated clock gate; registered.
REQ-010 TE  output  1  test enable to the integrated clock gate; registered copy of SCAN_EN.
REQ-011 ACK  output  1  gated clock guaranteed running; registered.
REQ-012 GATED  output  1  high while in state OFF; registered.

Function
REQ-013 FSM states: OFF, WAKE, ON, DRAIN; encoded as a 2-bit enum.
REQ-014 OFF: E=0, ACK=0, GATED=1; REQ=1 -> WAKE on the next edge.
REQ-015 WAKE: E=1, ACK=0, GATED=0; wake counter loads WAKE_CYCLES-1 on entry, decrements each cycle; at 0 -> ON.
REQ-016 WAKE ignores REQ deassertion; the wake sequence always completes into ON.
REQ-017 ON: E=1, ACK=1; idle counter increments when REQ=0 and BUSY=0, clears to 0 otherwise.
REQ-018 ON -> DRAIN when the idle counter equals IDLE_LIMIT-1, IDLE_LIMIT!=0, and REQ=0, BUSY=0 in the same cycle; ON is held indefinitely when IDLE_LIMIT=0.
REQ-019 The idle counter saturates at all-ones and never wraps.
REQ-020 DRAIN: E=1, ACK=0 for exactly one cycle; then REQ=1 or BUSY=1 -> ON (idle counter cleared), otherwise -> OFF.
REQ-021 A REQ/BUSY rise and an idle-limit hit in the same cycle resolve in favour of activity: stay ON, clear the counter.
REQ-022 IDLE_LIMIT is sampled every cycle; lowering it below the current count triggers DRAIN on the next qualifying idle cycle.
REQ-023 TE = SCAN_EN delayed one cycle, independent of FSM state; SCAN_EN has no effect on E, ACK or the FSM.
REQ-024 All outputs change only after posedge CLK, giving the ICG a full low phase of setup before its latch closes.
REQ-025 Latency: REQ rise in OFF -> ACK high after exactly WAKE_CYCLES+1 edges.

Reset
REQ-026 RST=1 asynchronously forces state OFF, E=0, TE=0, ACK=0, GATED=1, both counters 0.
REQ-027 RST asserted mid-WAKE or mid-ON aborts immediately; no DRAIN cycle is produced.
REQ-028 After RST deasserts, the first state change occurs no earlier than the first following posedge CLK.

Structure
REQ-029 Package icg_ctrl_pkg holds the state enum type, the WAKE_CYCLES and IDLE_W defaults, and the wake-counter width constant (4).
REQ-030 Sub-module icg_idle_cnt contains the saturating idle counter and the limit compare; the FSM and the output registers remain in icg_enable_ctrl.

Verification
REQ-031 Reset, then REQ=1 at cycle 0 with WAKE_CYCLES=2 -> E=1 after edge 1, ACK=1 after edge 3, GATED=0 throughout.
REQ-032 In ON with IDLE_LIMIT=4, REQ=0, BUSY=0 -> after 4 idle edges state DRAIN (E=1, ACK=0), next edge OFF (E=0, GATED=1).
REQ-033 In ON with IDLE_LIMIT=4, BUSY pulses high at idle count 3 -> counter clears to 0, no DRAIN, ACK stays 1.
REQ-034 REQ=1 during the DRAIN cycle -> returns to ON with ACK=1 on the next edge; E never drops.
REQ-035 IDLE_LIMIT=0, 300 idle cycles -> stays ON, idle counter saturates at 255, no wrap.
REQ-036 RST pulsed asynchronously mid-WAKE, and SCAN_EN toggled in OFF -> immediate OFF with all outputs at reset values; TE follows SCAN_EN one cycle later while E stays 0.

Source files
------------

// File: rtl/icg_ctrl_pkg.sv
// Shared types and defaults for the clock-gate enable controller.
// Imported by the FSM top and the idle counter.
package icg_ctrl_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_WAKE  = 2'd1,
    S_ON    = 2'd2,
    S_DRAIN = 2'd3
  } icg_state_t;

  localparam int WAKE_CYCLES_DEF = 2;
  localparam int IDLE_W_DEF      = 8;
  localparam int WCNT_W          = 4;

endpackage

// File: rtl/icg_idle_cnt.sv
// Saturating idle counter and idle-limit compare.
// Counts only while running and idle; any activity clears it.
module icg_idle_cnt
  import icg_ctrl_pkg::*;
#(
  parameter int IDLE_W = IDLE_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  input  logic              idle,
  input  logic [IDLE_W-1:0] limit,
  output logic              hit
);

  localparam logic [IDLE_W-1:0] ONE = {{(IDLE_W-1){1'b0}}, 1'b1};

  logic [IDLE_W-1:0] cnt;
  logic [IDLE_W-1:0] lim_m1;

  assign lim_m1 = limit - ONE;

  // >= so that a lowered limit still fires on the next idle cycle
  assign hit = run && idle && (limit != '0) && (cnt >= lim_m1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (!run || !idle) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/icg_enable_ctrl.sv
// Enable controller for an integrated clock gate: wake, run,
// idle-drain and gate, with registered E/TE/ACK/GATED.
module icg_enable_ctrl
  import icg_ctrl_pkg::*;
#(
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int IDLE_W      = IDLE_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              BUSY,
  input  logic              SCAN_EN,
  input  logic [IDLE_W-1:0] IDLE_LIMIT,
  output logic              E,
  output logic              TE,
  output logic              ACK,
  output logic              GATED
);

  localparam logic [WCNT_W-1:0] WLOAD = WCNT_W'(WAKE_CYCLES - 1);
  localparam logic [WCNT_W-1:0] WONE  = {{(WCNT_W-1){1'b0}}, 1'b1};

  icg_state_t        state;
  icg_state_t        nxt;
  logic [WCNT_W-1:0] wcnt;
  logic              active;
  logic              hit;

  assign active = REQ || BUSY;

  icg_idle_cnt #(
    .IDLE_W(IDLE_W)
  ) u_idle (
    .CLK  (CLK),
    .RST  (RST),
    .run  (state == S_ON),
    .idle (!active),
    .limit(IDLE_LIMIT),
    .hit  (hit)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_OFF:   if (REQ) nxt = S_WAKE;
      S_WAKE:  if (wcnt == '0) nxt = S_ON;
      S_ON:    if (hit) nxt = S_DRAIN;
      S_DRAIN: nxt = active ? S_ON : S_OFF;
      default: nxt = S_OFF;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_OFF;
      wcnt  <= '0;
    end else begin
      state <= nxt;
      if (state == S_OFF && nxt == S_WAKE) begin
        wcnt <= WLOAD;
      end else if (state == S_WAKE && wcnt != '0) begin
        wcnt <= wcnt - WONE;
      end
    end
  end

  // outputs decoded from next state so they align with state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      E     <= 1'b0;
      TE    <= 1'b0;
      ACK   <= 1'b0;
      GATED <= 1'b1;
    end else begin
      E     <= (nxt != S_OFF);
      TE    <= SCAN_EN;
      ACK   <= (nxt == S_ON);
      GATED <= (nxt == S_OFF);
    end
  end

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// Self-checking bench for icg_enable_ctrl: vector table with
// scoreboard queue plus hand-written reset and saturation cases.
module tb_icg_enable_ctrl;

  logic       CLK;
  logic       RST;
  logic       REQ;
  logic       BUSY;
  logic       SCAN_EN;
  logic [7:0] IDLE_LIMIT;
  logic       E;
  logic       TE;
  logic       ACK;
  logic       GATED;

  int checks;
  int failures;

  typedef struct {
    logic       req;
    logic       busy;
    logic       scan;
    logic [7:0] lim;
    logic       e;
    logic       ack;
    logic       gated;
  } vec_t;

  vec_t tbl[25];
  vec_t sb[$];

  icg_enable_ctrl #(
    .WAKE_CYCLES(2),
    .IDLE_W     (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .BUSY      (BUSY),
    .SCAN_EN   (SCAN_EN),
    .IDLE_LIMIT(IDLE_LIMIT),
    .E         (E),
    .TE        (TE),
    .ACK       (ACK),
    .GATED     (GATED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic b,
                              input logic s, input logic [7:0] l,
                              input logic e, input logic a,
                              input logic g);
    vec_t v;
    v.req = r; v.busy = b; v.scan = s; v.lim = l;
    v.e = e; v.ack = a; v.gated = g;
    return v;
  endfunction

  task automatic step(input vec_t v, input int idx);
    vec_t x;
    REQ = v.req; BUSY = v.busy; SCAN_EN = v.scan; IDLE_LIMIT = v.lim;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    x = sb.pop_front();
    chk("E", idx, {31'd0, E}, {31'd0, x.e});
    chk("ACK", idx, {31'd0, ACK}, {31'd0, x.ack});
    chk("GATED", idx, {31'd0, GATED}, {31'd0, x.gated});
    chk("TE", idx, {31'd0, TE}, {31'd0, x.scan});
  endtask

  int drops;

  initial begin
    checks = 0; failures = 0;
    RST = 1'b1; REQ = 1'b0; BUSY = 1'b0; SCAN_EN = 1'b0;
    IDLE_LIMIT = 8'd4;

    // r  b  s  lim   e  a  g
    tbl[0]  = mk(1, 0, 0, 8'd4, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 8'd4, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 8'd4, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 8'd4, 1, 1, 0);
    tbl[4]  = mk(0, 0, 0, 8'd4, 1, 1, 0);
    tbl[5]  = mk(0, 0, 0, 8'd4, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 8'd4, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 8'd4, 0, 0, 1);
    tbl[8]  = mk(1, 0, 0, 8'd4, 1, 0, 0);
    tbl[9]  = mk(1, 0, 0, 8'd4, 1, 0, 0);
    tbl[10] = mk(1, 0, 0, 8'd4, 1, 1, 0);
    tbl[11] = mk(0, 0, 0, 8'd4, 1, 1, 0);
    tbl[12] = mk(0, 0, 1, 8'd4, 1, 1, 0);
    tbl[13] = mk(0, 0, 0, 8'd4, 1, 1, 0);
    tbl[14] = mk(0, 1, 0, 8'd4, 1, 1, 0);
    tbl[15] = mk(0, 0, 0, 8'd4, 1, 1, 0);
    tbl[16] = mk(0, 0, 0, 8'd4, 1, 1, 0);
    tbl[17] = mk(0, 0, 0, 8'd4, 1, 1, 0);
    tbl[18] = mk(0, 0, 0, 8'd4, 1, 0, 0);
    tbl[19] = mk(1, 0, 0, 8'd4, 1, 1, 0);
    tbl[20] = mk(0, 0, 0, 8'd4, 1, 1, 0);
    tbl[21] = mk(0, 0, 0, 8'd1, 1, 0, 0);
    tbl[22] = mk(0, 0, 0, 8'd1, 0, 0, 1);
    tbl[23] = mk(0, 0, 1, 8'd1, 0, 0, 1);
    tbl[24] = mk(0, 0, 0, 8'd1, 0, 0, 1);

    #12;
    chk("rst_E", 0, {31'd0, E}, 32'd0);
    chk("rst_TE", 0, {31'd0, TE}, 32'd0);
    chk("rst_ACK", 0, {31'd0, ACK}, 32'd0);
    chk("rst_GATED", 0, {31'd0, GATED}, 32'd1);
    chk("rst_cnt", 0, {24'd0, dut.u_idle.cnt}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    foreach (tbl[i]) step(tbl[i], i);

    // limit 0: never drains, counter saturates
    IDLE_LIMIT = 8'd0;
    REQ = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("sat_on_ACK", 0, {31'd0, ACK}, 32'd1);
    REQ = 1'b0;
    drops = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge CLK);
      #1;
      if (ACK !== 1'b1) drops++;
      if (k == 259) chk("sat_cnt_260", 0, {24'd0, dut.u_idle.cnt}, 32'd255);
    end
    chk("sat_drops", 0, drops, 32'd0);
    chk("sat_cnt", 0, {24'd0, dut.u_idle.cnt}, 32'd255);

    // async reset mid-ON: no drain cycle afterwards
    #2 RST = 1'b1;
    #1;
    chk("on_rst_E", 0, {31'd0, E}, 32'd0);
    chk("on_rst_ACK", 0, {31'd0, ACK}, 32'd0);
    chk("on_rst_GATED", 0, {31'd0, GATED}, 32'd1);
    chk("on_rst_cnt", 0, {24'd0, dut.u_idle.cnt}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("post_rst_E", 0, {31'd0, E}, 32'd0);
    @(posedge CLK);
    #1;
    chk("no_drain_E", 0, {31'd0, E}, 32'd0);
    chk("no_drain_GATED", 0, {31'd0, GATED}, 32'd1);

    // async reset mid-WAKE with scan toggling
    REQ = 1'b1;
    @(posedge CLK);
    #1;
    chk("wake_E", 0, {31'd0, E}, 32'd1);
    #2 RST = 1'b1;
    SCAN_EN = 1'b1;
    #1;
    chk("wk_rst_E", 0, {31'd0, E}, 32'd0);
    chk("wk_rst_GATED", 0, {31'd0, GATED}, 32'd1);
    chk("wk_rst_TE", 0, {31'd0, TE}, 32'd0);
    @(negedge CLK);
    REQ = 1'b0;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("scan_TE", 1, {31'd0, TE}, 32'd1);
    chk("scan_E", 1, {31'd0, E}, 32'd0);
    chk("scan_GATED", 1, {31'd0, GATED}, 32'd1);
    SCAN_EN = 1'b0;
    @(posedge CLK);
    #1;
    chk("scan_TE", 2, {31'd0, TE}, 32'd0);
    chk("scan_E", 2, {31'd0, E}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
